// File: rtl/legv8_isa_pkg.sv
// LEGv8 subset ISA definitions shared by the instruction encoder and the CPU decoder.
package legv8_isa_pkg;

    typedef enum logic [3:0] {
        OP_B     = 4'd0,
        OP_BLT   = 4'd1,
        OP_CBZ   = 4'd2,
        OP_ADDS  = 4'd3,
        OP_SUBS  = 4'd4,
        OP_ADDI  = 4'd5,
        OP_LDUR  = 4'd6,
        OP_LDURB = 4'd7,
        OP_STUR  = 4'd8,
        OP_STURB = 4'd9,
        OP_MOVZ  = 4'd10,
        OP_MOVK  = 4'd11,
        OP_HALT  = 4'd12
    } op_e;

    localparam logic [5:0]  OPC_B     = 6'b000101;
    localparam logic [7:0]  OPC_BCOND = 8'b01010100;
    localparam logic [7:0]  OPC_CBZ   = 8'b10110100;
    localparam logic [10:0] OPC_ADDS  = 11'b10101011000;
    localparam logic [10:0] OPC_SUBS  = 11'b11101011000;
    localparam logic [9:0]  OPC_ADDI  = 10'b1001000100;
    localparam logic [10:0] OPC_LDUR  = 11'b11111000010;
    localparam logic [10:0] OPC_LDURB = 11'b00111000010;
    localparam logic [10:0] OPC_STUR  = 11'b11111000000;
    localparam logic [10:0] OPC_STURB = 11'b00111000000;
    localparam logic [8:0]  OPC_MOVZ  = 9'b110100101;
    localparam logic [8:0]  OPC_MOVK  = 9'b111100101;

    localparam logic [4:0]  COND_LT   = 5'b01011;
    localparam logic [31:0] HALT_WORD = 32'h14000000;

    typedef struct packed {
        op_e         op;
        logic [4:0]  rd;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [25:0] imm;
        logic [1:0]  hw;
    } enc_req_t;

endpackage

// File: rtl/legv8_field_pack.sv
// Combinational packer: symbolic op + fields -> 32-bit LEGv8 word.
// ENCODER_RANGE_CHECK_EN flags immediates with bits above the op's field width.
module legv8_field_pack
    import legv8_isa_pkg::*;
(
    input  enc_req_t    req,
    output logic [31:0] word,
    output logic        range_err
);

    always_comb begin
        word = '0;
        case (req.op)
            OP_B:     word = {OPC_B, req.imm};
            OP_BLT:   word = {OPC_BCOND, req.imm[18:0], COND_LT};
            OP_CBZ:   word = {OPC_CBZ, req.imm[18:0], req.rd};
            OP_ADDS:  word = {OPC_ADDS, req.rm, 6'b0, req.rn, req.rd};
            OP_SUBS:  word = {OPC_SUBS, req.rm, 6'b0, req.rn, req.rd};
            OP_ADDI:  word = {OPC_ADDI, req.imm[11:0], req.rn, req.rd};
            OP_LDUR:  word = {OPC_LDUR, req.imm[8:0], 2'b00, req.rn, req.rd};
            OP_LDURB: word = {OPC_LDURB, req.imm[8:0], 2'b00, req.rn, req.rd};
            OP_STUR:  word = {OPC_STUR, req.imm[8:0], 2'b00, req.rn, req.rd};
            OP_STURB: word = {OPC_STURB, req.imm[8:0], 2'b00, req.rn, req.rd};
            OP_MOVZ:  word = {OPC_MOVZ, req.hw, req.imm[15:0], req.rd};
            OP_MOVK:  word = {OPC_MOVK, req.hw, req.imm[15:0], req.rd};
            OP_HALT:  word = HALT_WORD;
            default:  word = '0;
        endcase
    end

`ifdef ENCODER_RANGE_CHECK_EN
    // B uses all 26 bits, register-only ops carry no immediate.
    always_comb begin
        range_err = 1'b0;
        case (req.op)
            OP_BLT, OP_CBZ:                       range_err = |req.imm[25:19];
            OP_ADDI:                              range_err = |req.imm[25:12];
            OP_LDUR, OP_LDURB, OP_STUR, OP_STURB: range_err = |req.imm[25:9];
            OP_MOVZ, OP_MOVK:                     range_err = |req.imm[25:16];
            default:                              range_err = 1'b0;
        endcase
    end
`else
    assign range_err = 1'b0;
`endif

endmodule

// File: rtl/legv8_instr_encoder.sv
// Instruction-memory loader: accepts symbolic LEGv8 beats, writes encoded words sequentially.
// Optional ENCODER_RANGE_CHECK_EN rejects over-wide immediates (see legv8_field_pack).
module legv8_instr_encoder
    import legv8_isa_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rn,
    input  logic [4:0]        in_rm,
    input  logic [25:0]       in_imm,
    input  logic [1:0]        in_hw,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W-2:0] count,
    output logic              done,
    output logic              err
);

    localparam int                DEPTH  = 2 ** (ADDR_W - 2);
    localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-2:0] DEPTH_C = (ADDR_W - 1)'(DEPTH);
    localparam logic [ADDR_W-2:0] LAST_C  = (ADDR_W - 1)'(DEPTH - 1);

    typedef enum logic {ST_LOAD, ST_DONE} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] next_addr_q;
    enc_req_t          req;
    logic [31:0]       word;
    logic              range_err;
    logic              accept, illegal, write_ok;

    assign req = '{op: op_e'(in_op), rd: in_rd, rn: in_rn, rm: in_rm, imm: in_imm, hw: in_hw};

    legv8_field_pack u_pack (
        .req       (req),
        .word      (word),
        .range_err (range_err)
    );

    assign accept   = in_valid && in_ready;
    assign illegal  = in_op > 4'd12;
    assign write_ok = accept && !illegal && !range_err;
    assign done     = (state_q == ST_DONE);

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_LOAD;
        else       state_q <= state_d;
    end

    // HALT and the last free slot both close the image on the cycle they are accepted.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            ST_LOAD: begin
                in_ready = (count < DEPTH_C);
                if (write_ok && (in_op == OP_HALT || count == LAST_C))
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                if (start) state_d = ST_LOAD;
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            next_addr_q <= BASE;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            count       <= '0;
            err         <= 1'b0;
        end else begin
            imem_we <= write_ok;
            if (write_ok) begin
                imem_addr   <= next_addr_q;
                imem_wdata  <= word;
                next_addr_q <= next_addr_q + ADDR_W'(4);
                count       <= count + 1'b1;
            end
            if (accept && (illegal || range_err))
                err <= 1'b1;
            if (state_q == ST_DONE && start) begin
                next_addr_q <= BASE;
                count       <= '0;
                err         <= 1'b0;
            end
        end
    end

endmodule

// File: doc/legv8_instr_encoder.md
Name: legv8_instr_encoder

Overview:
- Instruction-stream writer that encodes the LEGv8 subset executed by the pipelined CPU: B, B.LT, CBZ, ADDS, SUBS, ADDI, LDUR, LDURB, STUR, STURB, MOVZ and MOVK.
- Accepts one symbolic instruction per valid/ready beat and packs it into the 32-bit machine word the CPU control decoder expects.
- Writes each word to sequential instruction-memory addresses.
- Used by testbenches and the boot/program loader to fill instruction memory before the CPU is released from reset.

Parameters:
- ADDR_W, 10, byte-address width of the instruction-memory write port; DEPTH = 2**(ADDR_W-2) words.
- BASE_ADDR, 0, byte address of the first word written after reset or restart; must be 4-aligned.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; restarts loading from BASE_ADDR when in DONE.
- in_valid  in  1  symbolic instruction present.
- in_ready  out  1  encoder can accept a beat this cycle.
- in_op  in  4  op class: 0 B, 1 B.LT, 2 CBZ, 3 ADDS, 4 SUBS, 5 ADDI, 6 LDUR, 7 LDURB, 8 STUR, 9 STURB, 10 MOVZ, 11 MOVK, 12 HALT; 13-15 illegal.
- in_rd  in  5  Rd, or Rt for CBZ and loads/stores.
- in_rn  in  5  Rn.
- in_rm  in  5  Rm.
- in_imm  in  26  immediate, right-justified: BrAddr26 / CondAddr19 / imm12 / DAddr9 / imm16.
- in_hw  in  2  MOVZ/MOVK shift field.
- imem_we  out  1  write strobe.
- imem_addr  out  ADDR_W  byte address of the write.
- imem_wdata  out  32  encoded word.
- count  out  ADDR_W-1  number of words written since reset or start.
- done  out  1  high in DONE.
- err  out  1  sticky; set on an illegal op or a range violation; cleared by reset or start.

Behaviour:
- One clock, clk. reset is synchronous and active-high.
- Reset values: state LOAD, next address BASE_ADDR; imem_we, imem_addr, imem_wdata, count, done, err all 0.
- States:
  - LOAD: in_ready = 1 while count < DEPTH.
  - DONE: in_ready = 0; done = 1.
- A beat is accepted when in_valid && in_ready.
  - The registered write appears the next cycle: imem_we = 1 for exactly one cycle, with imem_addr = current next address and imem_wdata = encoded word.
  - Next address then advances by 4 and count increments.
  - Throughput is one beat per cycle.
- Encodings, with bit ranges inclusive:
  - B: [31:26]=000101, [25:0]=imm.
  - B.LT: [31:24]=01010100, [23:5]=imm[18:0], [4:0]=01011.
  - CBZ: [31:24]=10110100, [23:5]=imm[18:0], [4:0]=rd.
  - ADDS / SUBS: [31:21]=10101011000 / 11101011000, [20:16]=rm, [15:10]=0, [9:5]=rn, [4:0]=rd.
  - ADDI: [31:22]=1001000100, [21:10]=imm[11:0], [9:5]=rn, [4:0]=rd.
  - LDUR / LDURB / STUR / STURB: [31:21]=11111000010 / 00111000010 / 11111000000 / 00111000000, [20:12]=imm[8:0], [11:10]=00, [9:5]=rn, [4:0]=rd.
  - MOVZ / MOVK: [31:23]=110100101 / 111100101, [22:21]=hw, [20:5]=imm[15:0], [4:0]=rd.
- Unused input bits for an op are ignored; no sign extension is applied (the caller supplies two's-complement fields).
- HALT writes the self-loop word 0x14000000 (B #0), then enters DONE in the same cycle as that write.
- Illegal op (13-15): beat is consumed, err is set, no write, count unchanged.
- Full: the accepted beat that makes count == DEPTH transitions to DONE. in_ready is never high when count == DEPTH; the address never wraps.
- start:
  - In DONE, start returns to LOAD, reloads the address to BASE_ADDR, and clears count and err.
  - In LOAD, start is ignored.
  - start coincident with an accepted beat in LOAD: the beat proceeds normally.
- reset mid-operation: any pending write is squashed (imem_we = 0 in the cycle after reset); reset has priority over start and in_valid.

Optional Feature:
- Macro: ENCODER_RANGE_CHECK_EN.
- Defined: a beat whose in_imm has nonzero bits above the field width for its op is consumed without a write and sets err. Field widths are 26 for B, 19 for B.LT/CBZ, 12 for ADDI, 9 for D-format, 16 for MOV.
- Undefined: excess bits are silently truncated and err reflects illegal ops only.

Decomposition:
- Package legv8_isa_pkg holds:
  - the op-class enum;
  - opcode constants (OPC_B, OPC_BCOND, OPC_CBZ, OPC_ADDS, OPC_SUBS, OPC_ADDI, OPC_LDUR, OPC_LDURB, OPC_STUR, OPC_STURB, OPC_MOVZ, OPC_MOVK);
  - COND_LT = 5'b01011 and HALT_WORD = 32'h14000000.
- The decoder shares this package.
- One natural sub-module, legv8_field_pack: combinational op plus fields in, 32-bit word and range-error flag out. The top holds the FSM, address counter and output register.

Test Plan:
- ADDI X1,X31,#5 (op 5, rd 1, rn 31, imm 5) after reset -> next cycle imem_we=1, imem_addr=0, imem_wdata=0x910017E1, count=1.
- Back-to-back ADDS X3,X1,X2 then LDUR X4,[X1,#8] -> words 0xAB020023 @0 and 0xF8408024 @4 on consecutive cycles; in_ready stays 1.
- MOVZ X5,#0xBEEF,hw=1 then B.LT imm=0x7FFFE -> 0xD2B7DDE5, then 0x54FFFFCB.
- HALT -> 0x14000000 written, done=1, in_ready=0; start pulse -> done=0, next write lands at BASE_ADDR, count restarts at 1.
- ADDR_W=4 (DEPTH 4): 4 beats written @0,4,8,12 -> done=1; a fifth in_valid sees in_ready=0 and no write occurs.
- op=14 -> err=1, no write; with ENCODER_RANGE_CHECK_EN, ADDI imm=0x1000 -> err=1, no write, count unchanged; without the macro it writes 0x91000000|rn<<5|rd.
